// File: rtl/multichannel_audio_serializer_if.sv
// Frame-in / word-out handshake bundle for multichannel_audio_serializer.
// "slave" is the serializer itself; "master" is the surrounding audio path.
interface multichannel_audio_serializer_if #(
    parameter int audio_width = 32,
    parameter int channels    = 2
);
    localparam int ch_bits = (channels > 1) ? $clog2(channels) : 1;

    logic                            i_valid;
    logic                            i_ready;
    logic [channels*audio_width-1:0] i_data;
    logic [channels-1:0]             i_mask;
    logic                            o_valid;
    logic                            o_ready;
    logic [audio_width-1:0]          o_audio;
    logic [ch_bits-1:0]              o_channel;
    logic                            o_is_first;
    logic                            o_is_last;

    modport master (
        output i_valid, i_data, i_mask, o_ready,
        input  i_ready, o_valid, o_audio, o_channel, o_is_first, o_is_last
    );

    modport slave (
        input  i_valid, i_data, i_mask, o_ready,
        output i_ready, o_valid, o_audio, o_channel, o_is_first, o_is_last
    );
endinterface

// File: rtl/multichannel_audio_serializer.sv
// Serializes one frame of parallel channel words into per-channel words, skipping masked-off channels.
// Optional one-frame prefetch buffer: define MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN.
module multichannel_audio_serializer #(
    parameter int audio_width = 32,
    parameter int channels    = 2
) (
    input logic                           clk,
    input logic                           reset_n,
    multichannel_audio_serializer_if.slave bus
);
    localparam int ch_bits = (channels > 1) ? $clog2(channels) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                          state_q, state_d;
    logic [channels*audio_width-1:0] data_q, data_d;
    logic [channels-1:0]             rem_q, rem_d;
    logic                            first_q, first_d;
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
    logic [channels*audio_width-1:0] bufData_q, bufData_d;
    logic [channels-1:0]             bufMask_q, bufMask_d;
    logic                            bufFull_q, bufFull_d;
`endif

    logic [ch_bits-1:0]  curCh;
    logic [channels-1:0] remNext;
    logic                isLast;
    logic                outHs;
    logic                accept;
    logic                inReady;

    // rem_q holds the channels of the active frame not yet emitted; its lowest set bit is the current word.
    function automatic logic [ch_bits-1:0] lowestSet(input logic [channels-1:0] m);
        lowestSet = '0;
        for (int k = channels - 1; k >= 0; k--) begin
            if (m[k]) lowestSet = ch_bits'(k);
        end
    endfunction

    assign curCh   = lowestSet(rem_q);
    assign remNext = rem_q & (rem_q - channels'(1));
    assign isLast  = (remNext == '0);
    assign outHs   = (state_q == SHIFT) && bus.o_ready;
    assign accept  = bus.i_valid && inReady;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
            bufData_q <= '0;
            bufMask_q <= '0;
            bufFull_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            rem_q     <= rem_d;
            first_q   <= first_d;
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
            bufData_q <= bufData_d;
            bufMask_q <= bufMask_d;
            bufFull_q <= bufFull_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rem_d     = rem_q;
        first_d   = first_q;
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
        bufData_d = bufData_q;
        bufMask_d = bufMask_q;
        bufFull_d = bufFull_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept && (bus.i_mask != '0)) begin
                    state_d = SHIFT;
                    data_d  = bus.i_data;
                    rem_d   = bus.i_mask;
                    first_d = 1'b1;
                end
            end
            SHIFT: begin
                if (outHs && !isLast) begin
                    rem_d   = remNext;
                    first_d = 1'b0;
                end else if (outHs) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    first_d = 1'b0;
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
                    // A buffered frame takes over on the same edge; an empty-mask one is simply discarded.
                    if (bufFull_q) begin
                        bufFull_d = 1'b0;
                        if (bufMask_q != '0) begin
                            state_d = SHIFT;
                            data_d  = bufData_q;
                            rem_d   = bufMask_q;
                            first_d = 1'b1;
                        end
                    end else if (accept && (bus.i_mask != '0)) begin
                        state_d = SHIFT;
                        data_d  = bus.i_data;
                        rem_d   = bus.i_mask;
                        first_d = 1'b1;
                    end
`endif
                end
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
                if (accept && !(outHs && isLast)) begin
                    bufFull_d = 1'b1;
                    bufData_d = bus.i_data;
                    bufMask_d = bus.i_mask;
                end
`endif
            end
        endcase
    end

    // Outputs depend on registered state only, so they hold under backpressure and clear on reset.
    always_comb begin
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
        inReady = (state_q == IDLE) || !bufFull_q;
`else
        inReady = (state_q == IDLE);
`endif
        bus.i_ready    = inReady;
        bus.o_valid    = (state_q == SHIFT);
        bus.o_audio    = '0;
        bus.o_channel  = '0;
        bus.o_is_first = 1'b0;
        bus.o_is_last  = 1'b0;
        if (state_q == SHIFT) begin
            bus.o_audio    = data_q[int'(curCh)*audio_width +: audio_width];
            bus.o_channel  = curCh;
            bus.o_is_first = first_q;
            bus.o_is_last  = isLast;
        end
    end
endmodule

// File: tb/tb_multichannel_audio_serializer.sv
// Directed checks of multichannel_audio_serializer with a 2-channel and a 4-channel instance.
// Expectations follow MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN when it is defined.
module tb_multichannel_audio_serializer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic streamReady;

    multichannel_audio_serializer_if #(.audio_width(32), .channels(2)) bus2 ();
    multichannel_audio_serializer_if #(.audio_width(32), .channels(4)) bus4 ();

    multichannel_audio_serializer #(.audio_width(32), .channels(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );
    multichannel_audio_serializer #(.audio_width(32), .channels(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] D0 = 32'hD0D0_0000;
    localparam logic [31:0] D1 = 32'hD1D1_0001;
    localparam logic [31:0] D2 = 32'hD2D2_0002;
    localparam logic [31:0] D3 = 32'hD3D3_0003;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic v, input logic [127:0] d,
                                 input logic [3:0] m, input logic rdy);
        if (sel == 2) begin
            bus2.i_valid = v;
            bus2.i_data  = d[63:0];
            bus2.i_mask  = m[1:0];
            bus2.o_ready = rdy;
        end else begin
            bus4.i_valid = v;
            bus4.i_data  = d;
            bus4.i_mask  = m;
            bus4.o_ready = rdy;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBus(input int sel, input string tag, input logic v, input logic [1:0] ch,
                            input logic [31:0] au, input logic f, input logic l, input logic rdy);
        if (sel == 2) begin
            checkOutput({tag, ".valid"},   64'(bus2.o_valid),    64'(v));
            checkOutput({tag, ".channel"}, 64'(bus2.o_channel),  64'(ch));
            checkOutput({tag, ".audio"},   64'(bus2.o_audio),    64'(au));
            checkOutput({tag, ".first"},   64'(bus2.o_is_first), 64'(f));
            checkOutput({tag, ".last"},    64'(bus2.o_is_last),  64'(l));
            checkOutput({tag, ".iready"},  64'(bus2.i_ready),    64'(rdy));
        end else begin
            checkOutput({tag, ".valid"},   64'(bus4.o_valid),    64'(v));
            checkOutput({tag, ".channel"}, 64'(bus4.o_channel),  64'(ch));
            checkOutput({tag, ".audio"},   64'(bus4.o_audio),    64'(au));
            checkOutput({tag, ".first"},   64'(bus4.o_is_first), 64'(f));
            checkOutput({tag, ".last"},    64'(bus4.o_is_last),  64'(l));
            checkOutput({tag, ".iready"},  64'(bus4.i_ready),    64'(rdy));
        end
    endtask

    initial begin
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
        streamReady = 1'b1;
`else
        streamReady = 1'b0;
`endif
        applyStimulus(2, 1'b0, '0, 4'b0000, 1'b1);
        applyStimulus(4, 1'b0, '0, 4'b0000, 1'b1);

        #12;
        checkBus(2, "reset2", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkBus(4, "reset4", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        #10;
        reset_n = 1'b1;
        tick();

        // Stereo frame, both channels enabled
        applyStimulus(2, 1'b1, {64'h0, 32'h0000_0123, 32'h0000_ABCD}, 4'b0011, 1'b1);
        checkBus(2, "st.pre", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(2, "st.w0", 1'b1, 2'd0, 32'h0000_ABCD, 1'b1, 1'b0, streamReady);
        tick();
        checkBus(2, "st.w1", 1'b1, 2'd1, 32'h0000_0123, 1'b0, 1'b1, streamReady);
        tick();
        checkBus(2, "st.done", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Sparse mask 1010 on four channels, then an all-zero mask
        applyStimulus(4, 1'b1, {D3, D2, D1, D0}, 4'b1010, 1'b1);
        tick();
        applyStimulus(4, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(4, "sp.w1", 1'b1, 2'd1, D1, 1'b1, 1'b0, streamReady);
        tick();
        checkBus(4, "sp.w3", 1'b1, 2'd3, D3, 1'b0, 1'b1, streamReady);
        tick();
        checkBus(4, "sp.done", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4, 1'b1, {D3, D2, D1, D0}, 4'b0000, 1'b1);
        tick();
        applyStimulus(4, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(4, "zm.a", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkBus(4, "zm.b", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Backpressure held for five cycles on channel 1
        applyStimulus(4, 1'b1, {D3, D2, D1, D0}, 4'b1111, 1'b1);
        tick();
        applyStimulus(4, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(4, "bp.w0", 1'b1, 2'd0, D0, 1'b1, 1'b0, streamReady);
        tick();
        checkBus(4, "bp.w1", 1'b1, 2'd1, D1, 1'b0, 1'b0, streamReady);
        applyStimulus(4, 1'b0, '0, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkBus(4, "bp.hold", 1'b1, 2'd1, D1, 1'b0, 1'b0, streamReady);
        end
        applyStimulus(4, 1'b0, '0, 4'b0000, 1'b1);
        tick();
        checkBus(4, "bp.w2", 1'b1, 2'd2, D2, 1'b0, 1'b0, streamReady);
        tick();
        checkBus(4, "bp.w3", 1'b1, 2'd3, D3, 1'b0, 1'b1, streamReady);
        tick();
        checkBus(4, "bp.done", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Back-to-back stereo frames with i_valid held
        applyStimulus(2, 1'b1, {64'h0, 32'h2222_0001, 32'h1111_0000}, 4'b0011, 1'b1);
        tick();
        applyStimulus(2, 1'b1, {64'h0, 32'h4444_0001, 32'h3333_0000}, 4'b0011, 1'b1);
`ifdef MULTICHANNEL_AUDIO_SERIALIZER_PREFETCH_EN
        checkBus(2, "bb.a0", 1'b1, 2'd0, 32'h1111_0000, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(2, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(2, "bb.a1", 1'b1, 2'd1, 32'h2222_0001, 1'b0, 1'b1, 1'b0);
        tick();
        checkBus(2, "bb.b0", 1'b1, 2'd0, 32'h3333_0000, 1'b1, 1'b0, 1'b1);
        tick();
        checkBus(2, "bb.b1", 1'b1, 2'd1, 32'h4444_0001, 1'b0, 1'b1, 1'b1);
        tick();
        checkBus(2, "bb.done", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Buffered all-zero-mask frame is dropped at load time
        applyStimulus(2, 1'b1, {64'h0, 32'h6666_0001, 32'h5555_0000}, 4'b0011, 1'b1);
        tick();
        applyStimulus(2, 1'b1, {64'h0, 32'h7777_0001, 32'h7777_0000}, 4'b0000, 1'b1);
        checkBus(2, "zb.w0", 1'b1, 2'd0, 32'h5555_0000, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(2, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(2, "zb.w1", 1'b1, 2'd1, 32'h6666_0001, 1'b0, 1'b1, 1'b0);
        tick();
        checkBus(2, "zb.done", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
`else
        checkBus(2, "bb.a0", 1'b1, 2'd0, 32'h1111_0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkBus(2, "bb.a1", 1'b1, 2'd1, 32'h2222_0001, 1'b0, 1'b1, 1'b0);
        tick();
        checkBus(2, "bb.gap", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(2, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(2, "bb.b0", 1'b1, 2'd0, 32'h3333_0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkBus(2, "bb.b1", 1'b1, 2'd1, 32'h4444_0001, 1'b0, 1'b1, 1'b0);
        tick();
        checkBus(2, "bb.done", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
`endif

        // Asynchronous reset in the middle of a four-channel frame
        applyStimulus(4, 1'b1, {D3, D2, D1, D0}, 4'b1111, 1'b1);
        tick();
        applyStimulus(4, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(4, "rs.w0", 1'b1, 2'd0, D0, 1'b1, 1'b0, streamReady);
        tick();
        checkBus(4, "rs.w1", 1'b1, 2'd1, D1, 1'b0, 1'b0, streamReady);
        #2;
        reset_n = 1'b0;
        #1;
        checkBus(4, "rs.async", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        #10;
        reset_n = 1'b1;
        applyStimulus(4, 1'b1, {D3, D2, D1, D0}, 4'b0110, 1'b1);
        tick();
        applyStimulus(4, 1'b0, '0, 4'b0000, 1'b1);
        checkBus(4, "rs.n1", 1'b1, 2'd1, D1, 1'b1, 1'b0, streamReady);
        tick();
        checkBus(4, "rs.n2", 1'b1, 2'd2, D2, 1'b0, 1'b1, streamReady);
        tick();
        checkBus(4, "rs.done", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
